yutorina_rst_seq: RTL and testbench

YUTORINA_RST_SEQ -- requirements
Module: yutorina_rst_seq

---
 rtl/yutorina_rst_seq.sv | 89 ++++++++
 tb/tb_yutorina_rst_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_rst_seq.sv
// Staged reset sequencer: releases the bus, then the CPU, after chip reset.
// Also runs a CPU-only soft reset on a rising edge of soft_rst_req.
module yutorina_rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SOFT_PULSE  = 8
) (
  input  logic       clk,
  input  logic       chip_rst,
  input  logic       soft_rst_req,
  output logic       soft_rst_ack,
  output logic       bus_rst,
  output logic       cpu_rst,
  output logic       sys_ready,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_HOLD   = 3'd1,
    ST_BUS_UP = 3'd2,
    ST_RUN    = 3'd3,
    ST_SOFT   = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [7:0] SOFT_LAST = 8'(SOFT_PULSE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       req_q;
  logic       ack_nxt;
  logic       bus_nxt;
  logic       cpu_nxt;
  logic       rdy_nxt;

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    if (chip_rst) begin
      state_nxt = ST_RST;
    end else begin
      case (state)
        ST_RST:    state_nxt = ST_HOLD;
        ST_HOLD:
          if (cnt == HOLD_LAST) state_nxt = ST_BUS_UP;
        ST_BUS_UP:
          if (cnt == GAP_LAST) state_nxt = ST_RUN;
        ST_RUN:
          if (soft_rst_req && !req_q) state_nxt = ST_SOFT;
        ST_SOFT:
          if (cnt == SOFT_LAST) begin
            state_nxt = ST_BUS_UP;
            ack_nxt   = 1'b1;
          end
        // unused codes behave as RST
        default:   state_nxt = ST_HOLD;
      endcase
    end
    bus_nxt = (state_nxt == ST_RST) || (state_nxt == ST_HOLD);
    cpu_nxt = (state_nxt != ST_RUN);
    rdy_nxt = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (chip_rst) begin
      state        <= ST_RST;
      cnt          <= 8'd0;
      req_q        <= 1'b0;
      bus_rst      <= 1'b1;
      cpu_rst      <= 1'b1;
      sys_ready    <= 1'b0;
      soft_rst_ack <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      req_q        <= soft_rst_req;
      bus_rst      <= bus_nxt;
      cpu_rst      <= cpu_nxt;
      sys_ready    <= rdy_nxt;
      soft_rst_ack <= ack_nxt;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_yutorina_rst_seq.sv
// Bench for yutorina_rst_seq: default and minimum-parameter instances
// checked each cycle against a deadline-based timeline model.
module tb_yutorina_rst_seq;

  logic clk = 1'b0;
  logic chip_rst = 1'b1;
  logic soft_rst_req = 1'b0;

  logic       ack0, bus0, cpu0, rdy0;
  logic       ack1, bus1, cpu1, rdy1;
  logic [2:0] st0, st1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  yutorina_rst_seq u_def (
    .clk          (clk),
    .chip_rst     (chip_rst),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (ack0),
    .bus_rst      (bus0),
    .cpu_rst      (cpu0),
    .sys_ready    (rdy0),
    .seq_state    (st0)
  );

  yutorina_rst_seq #(
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1),
    .SOFT_PULSE  (1)
  ) u_min (
    .clk          (clk),
    .chip_rst     (chip_rst),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (ack1),
    .bus_rst      (bus1),
    .cpu_rst      (cpu1),
    .sys_ready    (rdy1),
    .seq_state    (st1)
  );

  logic [6:0] obs [2];
  assign obs[0] = {bus0, cpu0, rdy0, ack0, st0};
  assign obs[1] = {bus1, cpu1, rdy1, ack1, st1};

  int hc [2] = '{16, 1};
  int gc [2] = '{4, 1};
  int pc [2] = '{8, 1};

  bit         in_rst [2] = '{1'b1, 1'b1};
  bit         prev   [2];
  int         bus_at [2];
  int         run_at [2];
  int         soft_at[2];
  int         ack_at [2];
  int         exp_st [2];
  logic [6:0] exp_v  [2];

  // Model: each event sets absolute edge deadlines; the phase follows
  // from where the current edge lies relative to them.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    for (int i = 0; i < 2; i++) begin
      if (chip_rst) begin
        in_rst[i] = 1'b1;
        prev[i]   = 1'b0;
        exp_st[i] = 0;
        exp_v[i]  = 7'b1100_000;
      end else begin
        if (in_rst[i]) begin
          in_rst[i]  = 1'b0;
          bus_at[i]  = edge_n + hc[i];
          run_at[i]  = bus_at[i] + gc[i];
          soft_at[i] = -1;
          ack_at[i]  = -1;
        end else if (exp_st[i] == 3 && soft_rst_req && !prev[i]) begin
          soft_at[i] = edge_n;
          ack_at[i]  = edge_n + pc[i];
          run_at[i]  = ack_at[i] + gc[i];
        end
        prev[i] = soft_rst_req;
        if (soft_at[i] < 0 && edge_n < bus_at[i])
          exp_st[i] = 1;
        else if (soft_at[i] >= 0 && edge_n < ack_at[i])
          exp_st[i] = 4;
        else if (edge_n < run_at[i])
          exp_st[i] = 2;
        else
          exp_st[i] = 3;
        exp_v[i] = {exp_st[i] < 2, exp_st[i] != 3, exp_st[i] == 3,
                    edge_n == ack_at[i], 3'(exp_st[i])};
      end
    end
  end

  task automatic step(input logic r, input logic q);
    chip_rst     = r;
    soft_rst_req = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL reset inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_powerup;
    for (int n = 0; n < 25; n++) begin
      step(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL powerup inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_soft_pulse;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, n == 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL soft_pulse inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_hold_level;
    int acks = 0;
    for (int n = 0; n < 40; n++) begin
      step(1'b0, 1'b1);
      acks += int'(ack0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL hold_level inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (acks !== 1 || st0 !== 3'd3) begin
      errors++;
      $display("FAIL hold_level_once got acks=%0d st=%0d exp acks=1 st=3",
               acks, st0);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_req_from_reset;
    int soft_seen = 0;
    for (int n = 0; n < 33; n++) begin
      step(n < 3, 1'b1);
      if (st0 == 3'd4 || st1 == 3'd4) soft_seen++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL req_from_reset inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (soft_seen !== 0 || st0 !== 3'd3) begin
      errors++;
      $display("FAIL req_from_reset_nosoft got soft=%0d st=%0d exp 0 3",
               soft_seen, st0);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_glitch;
    logic r;
    logic q;
    for (int n = 0; n < 70; n++) begin
      r = (n == 0) || (n == 12) || (n == 44);
      q = (n == 39);
      step(r, q);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL glitch inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic q = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 5) == 0) q = ~q;
      step($urandom_range(0, 79) == 0, q);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL random inst%0d edge%0d got=%b exp=%b",
                   i, edge_n, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_powerup();
    test_soft_pulse();
    test_hold_level();
    test_req_from_reset();
    test_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
